// File: rtl/booth_pkg.sv
// Shared types and the radix-4 Booth digit decoder
// for the sequential partial-product generator.
package booth_pkg;

  typedef enum logic [2:0] {
    DIG_ZERO,
    DIG_POS1,
    DIG_POS2,
    DIG_NEG2,
    DIG_NEG1
  } booth_digit_e;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  function automatic booth_digit_e booth_decode(
    input logic [2:0] t
  );
    booth_digit_e d;
    d = DIG_ZERO;
    unique case (t)
      3'b001, 3'b010: d = DIG_POS1;
      3'b011:         d = DIG_POS2;
      3'b100:         d = DIG_NEG2;
      3'b101, 3'b110: d = DIG_NEG1;
      default:        d = DIG_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Combinational Booth digit encoder: selects 0/+-a/+-2a
// as one's complement plus a separate +1 bit.
module booth_r4_enc
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       triplet,
  input  logic [WIDTH+1:0] mcand,
  output logic [WIDTH+1:0] pp_data,
  output logic             pp_neg
);

  booth_digit_e dig;
  logic [WIDTH+1:0] dbl;

  assign dig = booth_decode(triplet);
  assign dbl = {mcand[WIDTH:0], 1'b0};

  // Map the digit onto a magnitude and its sign
  always_comb begin
    pp_data = '0;
    pp_neg  = 1'b0;
    unique case (dig)
      DIG_POS1: pp_data = mcand;
      DIG_POS2: pp_data = dbl;
      DIG_NEG2: begin
        pp_data = ~dbl;
        pp_neg  = 1'b1;
      end
      DIG_NEG1: begin
        pp_data = ~mcand;
        pp_neg  = 1'b1;
      end
      default: begin
        pp_data = '0;
        pp_neg  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/booth_r4_pp_gen.sv
// Sequential radix-4 Booth partial-product generator:
// one partial product per handshake, WIDTH/2 per operand pair.
module booth_r4_pp_gen
  import booth_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDXW  = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             pp_valid,
  input  logic             pp_ready,
  output logic [WIDTH+1:0] pp_data,
  output logic             pp_neg,
  output logic [IDXW-1:0]  pp_idx,
  output logic             pp_last
);

  localparam logic [IDXW-1:0] LAST = IDXW'(WIDTH / 2 - 1);

  state_e           state;
  state_e           state_nxt;
  logic [WIDTH+1:0] mcand;
  logic [WIDTH:0]   sr;
  logic [IDXW-1:0]  idx;
  logic [WIDTH+1:0] enc_data;
  logic             enc_neg;
  logic             run;
  logic             fire;
  logic             at_last;

  assign run     = (state == RUN);
  assign fire    = run & pp_ready;
  assign at_last = (idx == LAST);

  booth_r4_enc #(
    .WIDTH(WIDTH)
  ) u_enc (
    .triplet(sr[2:0]),
    .mcand  (mcand),
    .pp_data(enc_data),
    .pp_neg (enc_neg)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: accept in IDLE, leave RUN after last handoff
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_valid) state_nxt = RUN;
      RUN:  if (fire && at_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, digit shift and index advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      sr    <= '0;
      idx   <= '0;
    end else if (!run) begin
      if (in_valid) begin
        mcand <= {{2{a[WIDTH-1]}}, a};
        sr    <= {b, 1'b0};
        idx   <= '0;
      end
    end else if (fire && !at_last) begin
      sr  <= {{2{sr[WIDTH]}}, sr[WIDTH:2]};
      idx <= idx + IDXW'(1);
    end
  end

  // Outputs decoded from registered state; zeroed in IDLE
  always_comb begin
    in_ready = ~run;
    pp_valid = run;
    pp_data  = run ? enc_data : '0;
    pp_neg   = run & enc_neg;
    pp_idx   = run ? idx : '0;
    pp_last  = run & at_last;
  end

endmodule

// File: tb/tb_booth_r4_pp_gen.sv
// Self-checking bench for booth_r4_pp_gen: directed cases
// plus randomized operations against a digit-value model.
module tb_booth_r4_pp_gen;

  localparam int W  = 8;
  localparam int IW = 2;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         pp_valid;
  logic         pp_ready;
  logic [W+1:0] pp_data;
  logic         pp_neg;
  logic [IW-1:0] pp_idx;
  logic         pp_last;

  int n_chk;
  int n_pass;

  booth_r4_pp_gen #(
    .WIDTH(W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a       (a),
    .b       (b),
    .pp_valid(pp_valid),
    .pp_ready(pp_ready),
    .pp_data (pp_data),
    .pp_neg  (pp_neg),
    .pp_idx  (pp_idx),
    .pp_last (pp_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Booth digit i of multiplier bv, from its bit weights
  function automatic int digit(input logic [W-1:0] bv,
                               input int i);
    int lo;
    int d;
    lo = (i == 0) ? 0 : int'(bv[2*i-1]);
    d  = -2 * int'(bv[2*i+1]) + int'(bv[2*i]) + lo;
    return d;
  endfunction

  task automatic run_op(input logic [W-1:0] av,
                        input logic [W-1:0] bv,
                        input int rdy_pct, input int stall_at,
                        input bit junk);
    int     n;
    int     cyc;
    int     wt;
    int     stalls;
    int     d;
    longint ev;
    longint edat;
    longint sum;
    longint prod;
    logic [2*W-1:0] g16;
    logic [2*W-1:0] e16;
    bit     done;
    n = 0; cyc = 0; wt = 0; stalls = 0; sum = 0; done = 0;
    @(negedge clk);
    while (!in_ready && wt < 20) begin
      @(negedge clk);
      wt++;
    end
    check("in_ready_idle", longint'(in_ready), 1);
    a = av;
    b = bv;
    in_valid = 1'b1;
    pp_ready = 1'b0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      in_valid = junk ? 1'($urandom % 2) : 1'b0;
      if (junk) begin
        a = W'($urandom);
        b = W'($urandom);
      end
      pp_ready = (($urandom % 100) < rdy_pct);
      if (n == stall_at && stalls < 3) begin
        pp_ready = 1'b0;
        stalls++;
      end
      check("pp_valid", longint'(pp_valid), 1);
      if (!pp_valid) begin
        done = 1;
      end else begin
        d = digit(av, 0);
        d = digit(bv, n);
        ev = longint'(d) * longint'($signed(av));
        edat = (d < 0) ? ev - 1 : ev;
        check("in_ready_run", longint'(in_ready), 0);
        check("pp_idx", longint'(pp_idx), longint'(n));
        check("pp_data", longint'($signed(pp_data)), edat);
        check("pp_neg", longint'(pp_neg), longint'(d < 0));
        check("pp_last", longint'(pp_last), longint'(n == W/2-1));
        if (pp_ready) begin
          sum += (longint'($signed(pp_data)) + longint'(pp_neg))
                 * (longint'(1) << (2 * n));
          n++;
          if (pp_last) begin
            done = 1;
            in_valid = 1'b0;
          end
        end
      end
    end
    if (cyc >= 100) check("op_timeout", 0, 1);
    @(negedge clk);
    pp_ready = 1'b0;
    in_valid = 1'b0;
    check("pp_count", longint'(n), longint'(W/2));
    check("idle_valid", longint'(pp_valid), 0);
    check("idle_ready", longint'(in_ready), 1);
    check("idle_data", longint'(pp_data), 0);
    prod = longint'($signed(av)) * longint'($signed(bv));
    g16 = sum[2*W-1:0];
    e16 = prod[2*W-1:0];
    check("product", longint'(g16), longint'(e16));
  endtask

  logic [W-1:0] ra;
  logic [W-1:0] rb;

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    pp_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", longint'(in_ready), 1);
    check("rst_valid", longint'(pp_valid), 0);
    check("rst_data", longint'(pp_data), 0);
    check("rst_neg", longint'(pp_neg), 0);
    check("rst_idx", longint'(pp_idx), 0);
    check("rst_last", longint'(pp_last), 0);
    rst_n = 1'b1;

    run_op(8'd3, 8'd5, 100, -1, 0);
    run_op(8'h80, 8'h80, 100, -1, 0);
    run_op(8'd7, 8'hFF, 100, -1, 0);
    run_op(8'd3, 8'd5, 100, 1, 1);

    // Abort an operation with reset while digit 1 is shown
    @(negedge clk);
    a = 8'd3;
    b = 8'd5;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    pp_ready = 1'b1;
    check("abort_idx0", longint'(pp_idx), 0);
    @(negedge clk);
    pp_ready = 1'b0;
    check("abort_idx1", longint'(pp_idx), 1);
    rst_n = 1'b0;
    #1;
    check("abort_valid", longint'(pp_valid), 0);
    check("abort_ready", longint'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_valid", longint'(pp_valid), 0);
    run_op(8'd2, 8'd2, 100, -1, 0);

    for (int k = 0; k < 2500; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom % 8 == 0) ra = 8'h80;
      if ($urandom % 8 == 0) rb = 8'h80;
      run_op(ra, rb, 70, -1, 1'($urandom % 2));
      repeat ($urandom % 3) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
